// File: rtl/mrd_seq_pkg.sv
// Shared types for the radix-3 stage sequencer: FSM states, address triplet,
// and the in-flight depth rule.
package mrd_seq_pkg;

    localparam int unsigned W_ADDR = 12;
    localparam int unsigned W_CNT  = 10;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN,
        FIN
    } state_t;

    typedef struct packed {
        logic [W_ADDR-1:0] a0;
        logic [W_ADDR-1:0] a1;
        logic [W_ADDR-1:0] a2;
    } addr_trip_t;

    // Smallest slot count that can never overflow with a non-stallable engine.
    function automatic int unsigned safe_depth(input int unsigned depth,
                                               input int unsigned rd_lat,
                                               input int unsigned eng_lat);
        return (depth >= rd_lat + eng_lat + 1) ? depth : rd_lat + eng_lat + 1;
    endfunction

endpackage

// File: rtl/mrd_addr_fifo.sv
// Synchronous FIFO of address triplets; simultaneous push/pop allowed when full.
module mrd_addr_fifo
    import mrd_seq_pkg::*;
#(
    parameter int unsigned DEPTH = 8,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  addr_trip_t       din,
    input  logic             pop,
    output addr_trip_t       dout,
    output logic             empty,
    output logic             full,
    output logic [CNT_W-1:0] count
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    addr_trip_t       mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= inc(wr_ptr);
            if (do_pop)  rd_ptr <= inc(rd_ptr);
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    // Storage needs no reset; dout is only consumed while non-empty.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/mrd_rdx3_seq.sv
// Radix-3 stage sequencer: issues read triplets to the stage RAM, tracks them
// through read and engine latency, and emits in-place write-back triplets.
module mrd_rdx3_seq
    import mrd_seq_pkg::*;
#(
    parameter int unsigned RD_LAT     = 1,
    parameter int unsigned ENG_LAT    = 3,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [W_CNT-1:0]  cfg_m,
    input  logic [W_ADDR-1:0] cfg_base,
    input  logic [W_ADDR-1:0] cfg_stride,
    input  logic              hold,
    output logic              rd_en,
    output logic [W_ADDR-1:0] rd_addr0,
    output logic [W_ADDR-1:0] rd_addr1,
    output logic [W_ADDR-1:0] rd_addr2,
    output logic              eng_in_val,
    input  logic              eng_out_val,
    output logic              wr_en,
    output logic [W_ADDR-1:0] wr_addr0,
    output logic [W_ADDR-1:0] wr_addr1,
    output logic [W_ADDR-1:0] wr_addr2,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int unsigned DEPTH = safe_depth(FIFO_DEPTH, RD_LAT, ENG_LAT);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned OCC_W = $clog2(DEPTH + RD_LAT + 2);

    state_t            state;
    logic [W_CNT-1:0]  m_q;
    logic [W_CNT-1:0]  k_q;
    logic [W_ADDR-1:0] base_q;
    logic [W_ADDR-1:0] stride_q;
    addr_trip_t        rd_trip;
    logic [RD_LAT-1:0] pipe_val;
    addr_trip_t        pipe_trip [RD_LAT];
    addr_trip_t        fifo_dout;
    addr_trip_t        last_head;
    addr_trip_t        wr_trip;
    logic              fifo_empty;
    logic              fifo_full;
    logic [CNT_W-1:0]  fifo_cnt;
    logic [OCC_W-1:0]  occ;
    logic              room;
    logic              pop;
    logic              drained;

    logic              issue;
    logic              last_k;
    addr_trip_t        issue_trip;
    logic [W_ADDR-1:0] sel_base;
    logic [W_ADDR-1:0] sel_stride;
    logic [W_CNT-1:0]  sel_k;
    logic [W_CNT-1:0]  sel_m;

    assign rd_addr0   = rd_trip.a0;
    assign rd_addr1   = rd_trip.a1;
    assign rd_addr2   = rd_trip.a2;
    assign eng_in_val = pipe_val[RD_LAT-1];

    assign occ  = OCC_W'(fifo_cnt) + OCC_W'(rd_en) + OCC_W'($countones(pipe_val));
    assign room = !hold && !fifo_full && (occ < OCC_W'(DEPTH));

    // Write-back follows the engine directly from the FIFO head.
    assign pop      = eng_out_val && !fifo_empty;
    assign wr_en    = pop;
    assign wr_trip  = fifo_empty ? last_head : fifo_dout;
    assign wr_addr0 = wr_trip.a0;
    assign wr_addr1 = wr_trip.a1;
    assign wr_addr2 = wr_trip.a2;

    assign drained = !rd_en && (pipe_val == '0) &&
                     ((fifo_cnt == '0) || ((fifo_cnt == CNT_W'(1)) && pop));

    // The start cycle doubles as the issue slot for butterfly 0.
    always_comb begin
        sel_base   = base_q;
        sel_stride = stride_q;
        sel_k      = k_q;
        sel_m      = m_q;
        issue      = 1'b0;
        if (state == IDLE) begin
            sel_base   = cfg_base;
            sel_stride = cfg_stride;
            sel_k      = '0;
            sel_m      = cfg_m;
            issue      = start && (cfg_m != '0) && room;
        end else if (state == ISSUE) begin
            issue = room;
        end
        last_k        = (sel_k == sel_m - W_CNT'(1));
        issue_trip.a0 = sel_base + W_ADDR'(sel_k);
        issue_trip.a1 = issue_trip.a0 + sel_stride;
        issue_trip.a2 = issue_trip.a1 + sel_stride;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            m_q      <= '0;
            k_q      <= '0;
            base_q   <= '0;
            stride_q <= '0;
            rd_en    <= 1'b0;
            rd_trip  <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            rd_en <= issue;
            if (issue) rd_trip <= issue_trip;
            busy <= start || (state != IDLE);
            done <= (state == FIN);
            err  <= err || (eng_out_val && fifo_empty);
            case (state)
                IDLE: begin
                    if (start) begin
                        m_q      <= cfg_m;
                        base_q   <= cfg_base;
                        stride_q <= cfg_stride;
                        k_q      <= issue ? W_CNT'(1) : '0;
                        if (cfg_m == '0)         state <= FIN;
                        else if (issue && last_k) state <= DRAIN;
                        else                      state <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (issue) begin
                        k_q <= k_q + W_CNT'(1);
                        if (last_k) state <= DRAIN;
                    end
                end
                DRAIN: if (drained) state <= FIN;
                FIN:   state <= IDLE;
            endcase
        end
    end

    // Read-latency pipe carries each triplet until the engine accepts it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pipe_val  <= '0;
            last_head <= '0;
            for (int i = 0; i < int'(RD_LAT); i++) pipe_trip[i] <= '0;
        end else begin
            pipe_val[0]  <= rd_en;
            pipe_trip[0] <= rd_trip;
            for (int i = 1; i < int'(RD_LAT); i++) begin
                pipe_val[i]  <= pipe_val[i-1];
                pipe_trip[i] <= pipe_trip[i-1];
            end
            if (pop) last_head <= fifo_dout;
        end
    end

    mrd_addr_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (eng_in_val),
        .din   (pipe_trip[RD_LAT-1]),
        .pop   (pop),
        .dout  (fifo_dout),
        .empty (fifo_empty),
        .full  (fifo_full),
        .count (fifo_cnt)
    );

endmodule

// File: tb/tb_mrd_rdx3_seq.sv
// Bench for mrd_rdx3_seq: engine delay-line model plus a frame-level reference
// derived from issue slots, address arithmetic and fixed latencies.
module tb_mrd_rdx3_seq;
    import mrd_seq_pkg::*;

    localparam int RD_LAT  = 1;
    localparam int ENG_LAT = 3;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [W_CNT-1:0]  cfg_m;
    logic [W_ADDR-1:0] cfg_base;
    logic [W_ADDR-1:0] cfg_stride;
    logic              hold;
    logic              rd_en;
    logic [W_ADDR-1:0] rd_addr0, rd_addr1, rd_addr2;
    logic              eng_in_val;
    logic              eng_out_val;
    logic              wr_en;
    logic [W_ADDR-1:0] wr_addr0, wr_addr1, wr_addr2;
    logic              busy;
    logic              done;
    logic              err;

    logic [ENG_LAT-1:0] eng_sr = '0;
    logic               hold_pat [256];
    int checks = 0;
    int passes = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    // Radix-3 engine: fixed latency, never reset, never stalls.
    always @(posedge clk) eng_sr <= {eng_sr[ENG_LAT-2:0], eng_in_val};
    assign eng_out_val = eng_sr[ENG_LAT-1];

    mrd_rdx3_seq #(
        .RD_LAT     (RD_LAT),
        .ENG_LAT    (ENG_LAT),
        .FIFO_DEPTH (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .cfg_m       (cfg_m),
        .cfg_base    (cfg_base),
        .cfg_stride  (cfg_stride),
        .hold        (hold),
        .rd_en       (rd_en),
        .rd_addr0    (rd_addr0),
        .rd_addr1    (rd_addr1),
        .rd_addr2    (rd_addr2),
        .eng_in_val  (eng_in_val),
        .eng_out_val (eng_out_val),
        .wr_en       (wr_en),
        .wr_addr0    (wr_addr0),
        .wr_addr1    (wr_addr1),
        .wr_addr2    (wr_addr2),
        .busy        (busy),
        .done        (done),
        .err         (err)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_hold();
        for (int t = 0; t < 256; t++) hold_pat[t] = 1'b0;
    endtask

    // Runs one frame starting this cycle; expected events come from the hold
    // trace: butterfly k issues in the k-th hold-free cycle counting the start cycle.
    task automatic run_frame(input string name, input int m, input int base, input int stride,
                             input int restart_at, input logic exp_err);
        int          iss[$];
        logic [63:0] rd_q[$];
        logic [63:0] wr_q[$];
        logic [63:0] exp_ev;
        int          exp_done, done_at, done_cnt, busy_cnt;
        for (int t = 0; t < 256 && iss.size() < m; t++)
            if (!hold_pat[t]) iss.push_back(t);
        exp_done = (m == 0) ? 2 : iss[m-1] + 1 + RD_LAT + ENG_LAT + 2;
        done_at  = -1;
        done_cnt = 0;
        busy_cnt = 0;

        start      = 1'b1;
        cfg_m      = W_CNT'(m);
        cfg_base   = W_ADDR'(base);
        cfg_stride = W_ADDR'(stride);
        hold       = hold_pat[0];
        for (int t = 1; t <= exp_done + 3; t++) begin
            @(posedge clk); #1;
            start = (t == restart_at);
            if (t == restart_at) begin
                cfg_m      = W_CNT'(7);
                cfg_base   = W_ADDR'(100);
                cfg_stride = W_ADDR'(3);
            end
            hold = hold_pat[t];
            if (rd_en) rd_q.push_back({16'(t), rd_addr0, rd_addr1, rd_addr2});
            if (wr_en) wr_q.push_back({16'(t), wr_addr0, wr_addr1, wr_addr2});
            if (done) begin
                done_cnt++;
                if (done_at < 0) done_at = t;
            end
            if (busy) busy_cnt++;
        end
        start = 1'b0;
        hold  = 1'b0;

        check($sformatf("%s rd_count", name), rd_q.size(), m);
        check($sformatf("%s wr_count", name), wr_q.size(), m);
        for (int k = 0; k < m; k++) begin
            exp_ev = {16'(iss[k] + 1), 12'(base + k), 12'(base + k + stride), 12'(base + k + 2*stride)};
            check($sformatf("%s rd[%0d]", name, k), (k < rd_q.size()) ? rd_q[k] : '1, exp_ev);
            exp_ev[51:36] = 16'(iss[k] + 1 + RD_LAT + ENG_LAT);
            check($sformatf("%s wr[%0d]", name, k), (k < wr_q.size()) ? wr_q[k] : '1, exp_ev);
        end
        check($sformatf("%s done_cycle", name), done_at, exp_done);
        check($sformatf("%s done_pulses", name), done_cnt, 1);
        check($sformatf("%s busy_cycles", name), busy_cnt, exp_done);
        check($sformatf("%s err", name), err, exp_err);
    endtask

    initial begin
        int stray_wr, stray_out, m, base, stride;
        rst        = 1'b1;
        start      = 1'b0;
        hold       = 1'b0;
        cfg_m      = '0;
        cfg_base   = '0;
        cfg_stride = '0;
        clear_hold();
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs",
              {rd_en, eng_in_val, wr_en, busy, done, err, rd_addr0, rd_addr1, rd_addr2, wr_addr0}, '0);
        rst = 1'b0;
        @(posedge clk); #1;

        run_frame("basic", 4, 0, 4, -1, 1'b0);
        hold_pat[2] = 1'b1;
        hold_pat[3] = 1'b1;
        run_frame("hold2", 4, 0, 4, -1, 1'b0);
        clear_hold();
        run_frame("m0", 0, 0, 0, -1, 1'b0);
        run_frame("wrap", 2, 4094, 1, -1, 1'b0);
        run_frame("restart", 4, 0, 4, 2, 1'b0);

        for (int i = 0; i < 6; i++) begin
            m      = int'($urandom_range(1, 12));
            base   = int'($urandom_range(0, 4095));
            stride = int'($urandom_range(0, 4095));
            for (int t = 0; t < 256; t++) hold_pat[t] = (t > 0) && ($urandom_range(0, 3) == 0);
            run_frame($sformatf("rand%0d", i), m, base, stride, -1, 1'b0);
        end
        clear_hold();

        // Reset while butterfly 2 of 4 is on the read port.
        start      = 1'b1;
        cfg_m      = W_CNT'(4);
        cfg_base   = '0;
        cfg_stride = W_ADDR'(4);
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        check("rst_pre_rd", {rd_en, rd_addr0, rd_addr1, rd_addr2}, {1'b1, 12'd2, 12'd6, 12'd10});
        rst = 1'b1;
        #1;
        check("rst_async",
              {rd_en, eng_in_val, wr_en, busy, done, err, rd_addr0, rd_addr1, rd_addr2}, '0);
        @(posedge clk); #1;
        rst       = 1'b0;
        stray_wr  = 0;
        stray_out = 0;
        for (int t = 0; t < 8; t++) begin
            @(posedge clk); #1;
            if (wr_en) stray_wr++;
            if (eng_out_val) stray_out++;
        end
        check("stray_outval_seen", stray_out > 0, 1);
        check("stray_no_wr", stray_wr, 0);
        check("stray_err", err, 1);
        check("stray_idle", {busy, done}, 0);

        run_frame("post_rst", 4, 0, 4, -1, 1'b1);

        rst = 1'b1;
        #1;
        check("err_cleared", err, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
